// File: rtl/soc_sysid_uptime.sv
// soc_sysid_uptime -- Avalon-MM system-ID peripheral with uptime counter.
//
// Returns a fixed system ID and build timestamp. It also provides a prescaled
// free-running uptime counter with an atomic 64-bit read through a latched
// high word, a scratch register, an alarm-compare interrupt and a read latency
// of 1 or 2 cycles.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   address[2:0]   word address
//   read           read strobe, accepted every cycle
//   write          write strobe, accepted every cycle
//   writedata[31:0] write data
//   byteenable[3:0] byte lanes for RW registers
//   readdata[31:0] read data, valid while readdatavalid=1
//   readdatavalid  one-cycle pulse per accepted read
//   irq            registered IRQ_PEND & IRQ_EN
//
// Word map: 0 SYSID, 1 TIMESTAMP, 2 UPTIME_LO, 3 UPTIME_HI, 4 SCRATCH,
//           5 ALARM, 6 CTRL_STATUS {CNT_CLEAR, IRQ_EN, IRQ_PEND}, 7 PRESCALE
module soc_sysid_uptime #(
   parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'd1643044096,
   parameter int unsigned PRESCALE     = 50,
   parameter int unsigned UPTIME_WIDTH = 64,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid,
   output logic        irq
);

   typedef enum logic [2:0] {
      A_SYSID     = 3'd0,
      A_TIMESTAMP = 3'd1,
      A_UPTIME_LO = 3'd2,
      A_UPTIME_HI = 3'd3,
      A_SCRATCH   = 3'd4,
      A_ALARM     = 3'd5,
      A_CTRL      = 3'd6,
      A_PRESCALE  = 3'd7
   } addr_e;

   localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

   addr_e                   addr;
   logic [15:0]             presc;
   logic [UPTIME_WIDTH-1:0] uptime;
   logic [63:0]             uptime_ext;
   logic [31:0]             hi_latch;
   logic [31:0]             scratch;
   logic [31:0]             alarm;
   logic                    irq_pend;
   logic                    irq_en;
   logic                    tick;
   logic                    ctrl_wr;
   logic                    cnt_clear;
   logic                    alarm_hit;
   logic [31:0]             rd_mux;
   logic                    s1_valid;
   logic [31:0]             s1_data;

   assign addr = addr_e'(address);

   always_comb begin
      uptime_ext = '0;
      uptime_ext[UPTIME_WIDTH-1:0] = uptime;
   end

   assign tick      = (presc == PRESCALE_MAX);
   assign ctrl_wr   = write && (addr == A_CTRL) && byteenable[0];
   assign cnt_clear = ctrl_wr && writedata[2];
   // A clear swallows a coincident tick, so it can never raise the alarm.
   assign alarm_hit = tick && !cnt_clear && ((uptime_ext[31:0] + 32'd1) == alarm);

   // Prescaler and uptime counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc  <= '0;
         uptime <= '0;
      end else if (cnt_clear) begin
         presc  <= '0;
         uptime <= '0;
      end else begin
         presc <= tick ? '0 : presc + 16'd1;
         if (tick) begin
            uptime <= uptime + UPTIME_WIDTH'(1);
         end
      end
   end

   // RW registers and interrupt state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scratch  <= '0;
         alarm    <= '0;
         irq_pend <= 1'b0;
         irq_en   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (write && byteenable[i] && (addr == A_SCRATCH)) begin
               scratch[i*8 +: 8] <= writedata[i*8 +: 8];
            end
            if (write && byteenable[i] && (addr == A_ALARM)) begin
               alarm[i*8 +: 8] <= writedata[i*8 +: 8];
            end
         end
         if (ctrl_wr) begin
            irq_en <= writedata[1];
         end
         // Set has priority over a coincident write-1-to-clear.
         if (alarm_hit) begin
            irq_pend <= 1'b1;
         end else if (ctrl_wr && writedata[0]) begin
            irq_pend <= 1'b0;
         end
         irq <= irq_pend & irq_en;
      end
   end

   // Read data select, using pre-write register values
   always_comb begin
      rd_mux = '0;
      case (addr)
         A_SYSID:     rd_mux = SYSTEM_ID;
         A_TIMESTAMP: rd_mux = TIMESTAMP;
         A_UPTIME_LO: rd_mux = uptime_ext[31:0];
         A_UPTIME_HI: rd_mux = hi_latch;
         A_SCRATCH:   rd_mux = scratch;
         A_ALARM:     rd_mux = alarm;
         A_CTRL:      rd_mux = {29'd0, 1'b0, irq_en, irq_pend};
         A_PRESCALE:  rd_mux = 32'(PRESCALE);
         default:     rd_mux = '0;
      endcase
   end

   // First read stage; the high word is captured together with the low word
   // so a LO-then-HI read pair is coherent even if the counter carries.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         hi_latch <= '0;
      end else begin
         s1_valid <= read;
         if (read) begin
            s1_data <= rd_mux;
         end
         if (read && (addr == A_UPTIME_LO)) begin
            hi_latch <= uptime_ext[63:32];
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic        s2_valid;
         logic [31:0] s2_data;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign readdata      = s2_data;
         assign readdatavalid = s2_valid;
      end else begin : g_lat1
         assign readdata      = s1_data;
         assign readdatavalid = s1_valid;
      end
   endgenerate

endmodule

// File: tb/tb_soc_sysid_uptime.sv
// Testbench for soc_sysid_uptime. Three instances: defaults (d0),
// PRESCALE=1 (d1) for the atomic read, PRESCALE=4 / READ_LATENCY=2 (d2)
// for alarm, counter clear and reset during an in-flight read.
module tb_soc_sysid_uptime;

   typedef struct packed {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst           [3];
   logic [2:0]  address       [3];
   logic        read          [3];
   logic        write         [3];
   logic [31:0] writedata     [3];
   logic [3:0]  byteenable    [3];
   logic [31:0] readdata      [3];
   logic        readdatavalid [3];
   logic        irq           [3];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;
   int base  = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc_n++;

   soc_sysid_uptime dut_a (
      .clock(clock), .reset(rst[0]), .address(address[0]), .read(read[0]),
      .write(write[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
      .readdata(readdata[0]), .readdatavalid(readdatavalid[0]), .irq(irq[0])
   );

   soc_sysid_uptime #(.PRESCALE(1), .READ_LATENCY(1)) dut_b (
      .clock(clock), .reset(rst[1]), .address(address[1]), .read(read[1]),
      .write(write[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
      .readdata(readdata[1]), .readdatavalid(readdatavalid[1]), .irq(irq[1])
   );

   soc_sysid_uptime #(.PRESCALE(4), .READ_LATENCY(2)) dut_c (
      .clock(clock), .reset(rst[2]), .address(address[2]), .read(read[2]),
      .write(write[2]), .writedata(writedata[2]), .byteenable(byteenable[2]),
      .readdata(readdata[2]), .readdatavalid(readdatavalid[2]), .irq(irq[2])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lat(input int d);
      return (d == 2) ? 2 : 1;
   endfunction

   task automatic push(input int d, input logic [31:0] data);
      exp_t e;
      e.data = data;
      e.due  = cyc_n + lat(d);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int d);
      read[d]  = 1'b0;
      write[d] = 1'b0;
   endtask

   task automatic issue_rd(input int d, input logic [2:0] a, input logic [31:0] exp,
                           input bit expect_data = 1'b1);
      address[d] = a;
      read[d]    = 1'b1;
      write[d]   = 1'b0;
      if (expect_data) push(d, exp);
      step();
      idle(d);
   endtask

   task automatic issue_wr(input int d, input logic [2:0] a, input logic [31:0] data,
                           input logic [3:0] be);
      address[d]    = a;
      read[d]       = 1'b0;
      write[d]      = 1'b1;
      writedata[d]  = data;
      byteenable[d] = be;
      step();
      idle(d);
   endtask

   task automatic issue_rw(input int d, input logic [2:0] a, input logic [31:0] data,
                           input logic [3:0] be, input logic [31:0] exp);
      address[d]    = a;
      read[d]       = 1'b1;
      write[d]      = 1'b1;
      writedata[d]  = data;
      byteenable[d] = be;
      push(d, exp);
      step();
      idle(d);
   endtask

   // Monitor: pops the oldest expectation whenever a DUT presents read data.
   task automatic mon(input int d);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (d)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         chk($sformatf("d%0d_unexpected_rdv", d), 32'd1, 32'd0);
      end else begin
         chk($sformatf("d%0d_rdata", d), readdata[d], e.data);
         chk($sformatf("d%0d_rlat", d), cyc_n, e.due);
      end
   endtask

   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         if (readdatavalid[d] === 1'b1) mon(d);
      end
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         idle(d);
         address[d]    = '0;
         writedata[d]  = '0;
         byteenable[d] = '0;
      end
      repeat (2) step();

      // Reset state
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_rst_rdata", d), readdata[d], 32'd0);
         chk($sformatf("d%0d_rst_rdv", d), 32'(readdatavalid[d]), 32'd0);
         chk($sformatf("d%0d_rst_irq", d), 32'(irq[d]), 32'd0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      step();

      // d0: constant words back-to-back
      issue_rd(0, 3'd0, 32'h0000_0000);
      issue_rd(0, 3'd1, 32'd1643044096);
      issue_rd(0, 3'd7, 32'd50);

      // d0: scratch byte lanes and read-before-write
      issue_wr(0, 3'd4, 32'hA5A5_A5A5, 4'b0101);
      issue_rd(0, 3'd4, 32'h00A5_00A5);
      issue_rw(0, 3'd4, 32'hFFFF_FFFF, 4'b1111, 32'h00A5_00A5);
      issue_rd(0, 3'd4, 32'hFFFF_FFFF);

      // d0: RO words ignore writes; alarm lanes
      issue_wr(0, 3'd0, 32'hDEAD_BEEF, 4'b1111);
      issue_rd(0, 3'd0, 32'h0000_0000);
      issue_wr(0, 3'd7, 32'h1234_5678, 4'b1111);
      issue_rd(0, 3'd7, 32'd50);
      issue_wr(0, 3'd5, 32'h1234_5678, 4'b1000);
      issue_rd(0, 3'd5, 32'h1200_0000);
      step();

      // d1: atomic 64-bit read across a carry into the high word
      @(negedge clock);
      force dut_b.uptime = 64'h0000_0001_FFFF_FFFF;
      issue_rd(1, 3'd2, 32'hFFFF_FFFF);
      release dut_b.uptime;
      repeat (3) step();
      issue_rd(1, 3'd3, 32'h0000_0001);
      issue_rd(1, 3'd3, 32'h0000_0001);
      step();

      // d2: alarm at uptime 10 with PRESCALE=4 -> IRQ_PEND at edge 40
      rst[2] = 1'b0;
      base = cyc_n;
      issue_wr(2, 3'd5, 32'd10, 4'b1111);
      issue_wr(2, 3'd6, 32'h0000_0002, 4'b0001);
      issue_rd(2, 3'd6, 32'h0000_0002);
      for (int k = 0; k < 100 && cyc_n != base + 40; k++) @(negedge clock);
      chk("alarm_wait", cyc_n, base + 40);
      chk("irq_before", 32'(irq[2]), 32'd0);
      issue_rd(2, 3'd6, 32'h0000_0003);
      chk("irq_rise", 32'(irq[2]), 32'd1);
      issue_rd(2, 3'd2, 32'd10);
      issue_wr(2, 3'd6, 32'h0000_0003, 4'b0001);
      chk("irq_hold", 32'(irq[2]), 32'd1);
      step();
      chk("irq_fall", 32'(irq[2]), 32'd0);
      issue_rd(2, 3'd6, 32'h0000_0002);

      // d2: counter clear with ALARM=0 must not raise IRQ_PEND
      issue_wr(2, 3'd5, 32'd0, 4'b1111);
      issue_wr(2, 3'd6, 32'h0000_0006, 4'b0001);
      issue_rd(2, 3'd2, 32'd0);
      issue_rd(2, 3'd6, 32'h0000_0002);
      repeat (4) step();
      chk("irq_after_clear", 32'(irq[2]), 32'd0);

      // d2: reset while a latency-2 read is in flight
      issue_rd(2, 3'd1, 32'd0, 1'b0);
      rst[2] = 1'b1;
      @(negedge clock);
      chk("inflight_rst_rdata", readdata[2], 32'd0);
      chk("inflight_rst_rdv", 32'(readdatavalid[2]), 32'd0);
      chk("inflight_rst_irq", 32'(irq[2]), 32'd0);
      repeat (4) step();
      rst[2] = 1'b0;
      repeat (4) step();

      chk("pending_reads", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
